// File: rtl/move_ball.sv
// Ball motion controller: serves from the bar, bounces off walls and the bar,
// and tracks misses, lives and the LOST/OVER game states.
module move_ball #(
    parameter int R_BALL     = 4,
    parameter int STEP       = 4,
    parameter int W_BAR      = 64,
    parameter int H_BAR      = 8,
    parameter int LOST_TICKS = 60,
    parameter int LIVES_INIT = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] bar_x,
    input  logic [9:0] bar_y,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       posicao,
    output logic       hit,
    output logic       lost,
    output logic [1:0] lives,
    output logic [1:0] estado
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MOVE = 2'd1;
    localparam logic [1:0] LOST = 2'd2;
    localparam logic [1:0] OVER = 2'd3;

    localparam int CW = $clog2(LOST_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOST_TICKS - 1);

    localparam logic [10:0] R11    = 11'(R_BALL);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [10:0] W11    = 11'(W_BAR);
    localparam logic [10:0] H11    = 11'(H_BAR);
    localparam logic [10:0] XMAX11 = 11'(640 - R_BALL);
    localparam logic [10:0] YMAX11 = 11'(480 - R_BALL);
    localparam logic [9:0]  R10    = 10'(R_BALL);
    localparam logic [9:0]  STEP10 = 10'(STEP);
    localparam logic [9:0]  XMAX10 = 10'(640 - R_BALL);
    localparam logic [9:0]  YOFF10 = 10'(H_BAR + R_BALL);

    logic [1:0]    state_q, state_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          dx_q, dx_d;   // 1 = right
    logic          dy_q, dy_d;   // 1 = up
    logic [1:0]    lives_q, lives_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit_q, hit_d;
    logic          lost_q, lost_d;

    logic [10:0] x_w, y_w, bx_w, by_w, nx_w, ny_w;
    logic        bar_hit;

    always_comb begin
        x_w  = {1'b0, x_q};
        y_w  = {1'b0, y_q};
        bx_w = {1'b0, bar_x};
        by_w = {1'b0, bar_y};
        nx_w = {1'b0, next_x};
        ny_w = {1'b0, next_y};
    end

    // Bar-top terms are moved to the other side so nothing underflows.
    always_comb begin
        bar_hit = (y_w + R11 + H11 <= by_w) &&
                  (y_w + R11 + STEP11 + H11 >= by_w) &&
                  (x_w + W11 + R11 >= bx_w) &&
                  (x_w <= bx_w + W11 + R11);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        lost_d  = 1'b0;
        case (state_q)
            IDLE: begin
                x_d = bar_x;
                y_d = bar_y - YOFF10;
                if (!start && lives_q != 2'd0) begin
                    state_d = MOVE;
                    dx_d    = 1'b1;
                    dy_d    = 1'b1;
                end
            end
            MOVE: begin
                if (tick) begin
                    if (dx_q) begin
                        if (x_w + STEP11 >= XMAX11) begin
                            x_d  = XMAX10;
                            dx_d = 1'b0;
                        end else begin
                            x_d = x_q + STEP10;
                        end
                    end else if (x_w <= R11 + STEP11) begin
                        x_d  = R10;
                        dx_d = 1'b1;
                    end else begin
                        x_d = x_q - STEP10;
                    end

                    if (dy_q) begin
                        if (y_w <= R11 + STEP11) begin
                            y_d  = R10;
                            dy_d = 1'b0;
                        end else begin
                            y_d = y_q - STEP10;
                        end
                    end else if (bar_hit) begin
                        // A centred hit leaves the wall-rule dx result in place.
                        y_d   = bar_y - YOFF10;
                        dy_d  = 1'b1;
                        hit_d = 1'b1;
                        if (x_q < bar_x) begin
                            dx_d = 1'b0;
                        end else if (x_q > bar_x) begin
                            dx_d = 1'b1;
                        end
                    end else if (y_w + STEP11 >= YMAX11) begin
                        lost_d  = 1'b1;
                        lives_d = lives_q - 2'd1;
                        state_d = (lives_q > 2'd1) ? LOST : OVER;
                    end else begin
                        y_d = y_q + STEP10;
                    end
                end
            end
            LOST: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= 10'd320;
            y_q     <= 10'd452;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            lives_q <= 2'(LIVES_INIT);
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        posicao = (nx_w + R11 >= x_w) && (nx_w <= x_w + R11) &&
                  (ny_w + R11 >= y_w) && (ny_w <= y_w + R11);
    end

    assign x      = x_q;
    assign y      = y_q;
    assign hit    = hit_q;
    assign lost   = lost_q;
    assign lives  = lives_q;
    assign estado = state_q;

endmodule

// File: tb/tb_move_ball.sv
// Directed bench for move_ball: serve, wall bounces, bar hit, misses, game over
// and asynchronous reset, with hand-computed positions.
module tb_move_ball;

    logic       clock;
    logic       reset;
    logic       tick;
    logic       start;
    logic [9:0] bar_x;
    logic [9:0] bar_y;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic [9:0] x;
    logic [9:0] y;
    logic       posicao;
    logic       hit;
    logic       lost;
    logic [1:0] lives;
    logic [1:0] estado;

    int checks = 0;
    int errors = 0;

    move_ball #(
        .R_BALL(4), .STEP(4), .W_BAR(64), .H_BAR(8), .LOST_TICKS(60), .LIVES_INIT(3)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick), .start(start),
        .bar_x(bar_x), .bar_y(bar_y), .next_x(next_x), .next_y(next_y),
        .x(x), .y(y), .posicao(posicao), .hit(hit), .lost(lost),
        .lives(lives), .estado(estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, 32'(x), 32'd320);
        chk({tag, "_y"}, 32'(y), 32'd452);
        chk({tag, "_estado"}, 32'(estado), 32'd0);
        chk({tag, "_lives"}, 32'(lives), 32'd3);
        chk({tag, "_hit"}, 32'(hit), 32'd0);
        chk({tag, "_lost"}, 32'(lost), 32'd0);
    endtask

    initial begin
        reset  = 1'b0;
        tick   = 1'b0;
        start  = 1'b1;
        bar_x  = 10'd320;
        bar_y  = 10'd464;
        next_x = 10'd0;
        next_y = 10'd0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk_reset_vals("rst");

        // IDLE tracking, launch with a coincident tick, first move
        bar_x = 10'd200;
        step();
        chk("idle_track_x", 32'(x), 32'd200);
        chk("idle_track_y", 32'(y), 32'd452);
        start = 1'b0;
        tick  = 1'b1;
        step();
        start = 1'b1;
        tick  = 1'b0;
        chk("launch_estado", 32'(estado), 32'd1);
        chk("launch_tick_ignored_x", 32'(x), 32'd200);
        chk("launch_tick_ignored_y", 32'(y), 32'd452);
        ticks(1);
        chk("tick1_x", 32'(x), 32'd204);
        chk("tick1_y", 32'(y), 32'd448);

        // posicao inclusive box around (204,448)
        next_x = 10'd208; next_y = 10'd444; #1;
        chk("pos_corner", 32'(posicao), 32'd1);
        next_x = 10'd209; #1;
        chk("pos_right_out", 32'(posicao), 32'd0);
        next_x = 10'd204; next_y = 10'd443; #1;
        chk("pos_top_out", 32'(posicao), 32'd0);
        next_x = 10'd200; next_y = 10'd452; #1;
        chk("pos_left_bottom", 32'(posicao), 32'd1);

        // asynchronous reset mid-MOVE, no clock edge in between
        reset = 1'b0;
        #2;
        chk_reset_vals("async_move");

        // wall bounces from a launch at bar_x=576
        bar_x = 10'd576;
        step();
        reset = 1'b1;
        step();
        chk("idle_576_x", 32'(x), 32'd576);
        start = 1'b0;
        step();
        start = 1'b1;
        chk("launch2_estado", 32'(estado), 32'd1);
        ticks(15);
        chk("right_wall_x", 32'(x), 32'd636);
        ticks(1);
        chk("after_right_wall_x", 32'(x), 32'd632);
        ticks(96);
        chk("top_wall_y", 32'(y), 32'd4);
        ticks(1);
        chk("descend_y", 32'(y), 32'd8);
        ticks(110);
        chk("pre_hit_y", 32'(y), 32'd448);
        chk("pre_hit_x", 32'(x), 32'd204);

        // bar hit with ball left of bar centre
        bar_x = 10'd214;
        ticks(1);
        chk("hit_y", 32'(y), 32'd452);
        chk("hit_x", 32'(x), 32'd208);
        chk("hit_pulse", 32'(hit), 32'd1);
        chk("hit_no_lost", 32'(lost), 32'd0);
        step();
        chk("hit_one_cycle", 32'(hit), 32'd0);
        chk("hold_without_tick", 32'(x), 32'd208);
        bar_x = 10'd1000;
        ticks(1);
        chk("hit_dx_left", 32'(x), 32'd204);
        chk("hit_dy_up", 32'(y), 32'd448);

        // first miss
        ticks(228);
        chk("pre_miss_y", 32'(y), 32'd472);
        chk("pre_miss_lost", 32'(lost), 32'd0);
        chk("pre_miss_estado", 32'(estado), 32'd1);
        ticks(1);
        chk("miss1_lost", 32'(lost), 32'd1);
        chk("miss1_hit", 32'(hit), 32'd0);
        chk("miss1_lives", 32'(lives), 32'd2);
        chk("miss1_estado", 32'(estado), 32'd2);
        step();
        chk("lost_one_cycle", 32'(lost), 32'd0);
        start = 1'b0;
        step();
        start = 1'b1;
        chk("lost_ignores_start", 32'(estado), 32'd2);
        ticks(59);
        chk("lost_59", 32'(estado), 32'd2);
        ticks(1);
        chk("lost_60", 32'(estado), 32'd0);
        bar_x = 10'd300;
        step();
        chk("post_lost_track_x", 32'(x), 32'd300);
        chk("post_lost_track_y", 32'(y), 32'd452);

        // second miss
        start = 1'b0;
        step();
        start = 1'b1;
        bar_x = 10'd1000;
        ticks(229);
        chk("miss2_pre_y", 32'(y), 32'd472);
        ticks(1);
        chk("miss2_lives", 32'(lives), 32'd1);
        chk("miss2_estado", 32'(estado), 32'd2);
        ticks(60);
        chk("miss2_idle", 32'(estado), 32'd0);
        bar_x = 10'd300;
        step();

        // third miss -> game over
        start = 1'b0;
        step();
        start = 1'b1;
        bar_x = 10'd1000;
        ticks(230);
        chk("miss3_lost", 32'(lost), 32'd1);
        chk("miss3_lives", 32'(lives), 32'd0);
        chk("miss3_estado", 32'(estado), 32'd3);
        start = 1'b0;
        step();
        start = 1'b1;
        ticks(5);
        chk("over_stays", 32'(estado), 32'd3);
        chk("over_lives", 32'(lives), 32'd0);
        chk("over_no_lost", 32'(lost), 32'd0);
        chk("over_no_hit", 32'(hit), 32'd0);

        // asynchronous reset out of OVER
        reset = 1'b0;
        #2;
        chk_reset_vals("async_over");
        bar_x = 10'd320;
        step();
        reset = 1'b1;
        step();
        chk("rerun_estado", 32'(estado), 32'd0);
        chk("rerun_lives", 32'(lives), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_ball.md
MOVE_BALL -- requirements
Module: move_ball

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- R_BALL, 4: ball half-size in pixels.
- STEP, 4: pixels moved per tick, per axis.
- W_BAR, 64: bar half-width.
- H_BAR, 8: bar half-height.
- LOST_TICKS, 60: ticks held in LOST.
- LIVES_INIT, 3: lives at reset.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- tick, input, 1: one-cycle movement strobe from the game timer.
- start, input, 1: active-low launch pushbutton.
- bar_x, input, 10: bar centre x, from move_bar.
- bar_y, input, 10: bar centre y, from move_bar.
- next_x, input, 10: pixel x being drawn.
- next_y, input, 10: pixel y being drawn.
- x, output, 10: ball centre x.
- y, output, 10: ball centre y.
- posicao, output, 1: drawn pixel lies inside the ball.
- hit, output, 1: one-cycle pulse on a bar bounce.
- lost, output, 1: one-cycle pulse on a miss.
- lives, output, 2: remaining lives.
- estado, output, 2: current FSM state.

Function
REQ-003 FSM states: IDLE=0, MOVE=1, LOST=2, OVER=3.

REQ-004 IDLE behaviour:
- Every cycle: x=bar_x, y=bar_y-H_BAR-R_BALL.
- start==0 with lives>0 -> MOVE next cycle, dx=+1 (right), dy=up.
- A tick in that same cycle is ignored.

REQ-005 MOVE: position updates only on cycles with tick==1; x and y hold otherwise.

REQ-006 X axis, per tick:
- dx right and x+STEP >= 640-R_BALL -> x=640-R_BALL, dx=left.
- dx left and x-STEP <= R_BALL -> x=R_BALL, dx=right.
- Otherwise x moves by STEP in direction dx.

REQ-007 Y axis, moving up, per tick: y-STEP <= R_BALL -> y=R_BALL, dy=down; otherwise y=y-STEP.

REQ-008 Y axis, moving down, bar-hit condition (all must hold):
- y+R_BALL <= bar_y-H_BAR.
- y+R_BALL+STEP >= bar_y-H_BAR.
- bar_x-W_BAR-R_BALL <= x <= bar_x+W_BAR+R_BALL.
On a bar hit:
- y=bar_y-H_BAR-R_BALL, dy=up, hit=1 for one cycle.
- dx=left if x<bar_x; dx=right if x>bar_x; dx unchanged if equal.

REQ-009 Y axis, moving down, no bar hit:
- y+STEP >= 480-R_BALL -> lost=1 for one cycle, lives decrements, state becomes LOST if the new lives>0, else OVER.
- Otherwise y=y+STEP.

REQ-010 Priority and simultaneous events:
- Bar hit has priority over the floor miss.
- X and Y rules apply independently in the same tick, so a corner flips both directions.
- On the miss tick, x keeps its REQ-006 update.

REQ-011 All comparisons use 11-bit unsigned intermediates; no wrap below 0 or above 1023.

REQ-012 LOST: count ticks, freeze x/y, ignore start; after LOST_TICKS ticks, go to IDLE and clear the counter.

REQ-013 OVER is terminal: x/y frozen, start ignored, lives=0; only reset exits.

REQ-014 posicao is combinational: next_x in [x-R_BALL, x+R_BALL] and next_y in [y-R_BALL, y+R_BALL], inclusive.

REQ-015 hit and lost are registered, never high together, and never asserted outside MOVE.

REQ-016 estado reflects the registered state; all outputs except posicao are registered.

Reset
REQ-017 reset==0 asynchronously forces:
- estado=IDLE, x=320, y=452, dx=right, dy=up.
- lives=LIVES_INIT, LOST counter=0, hit=0, lost=0.

REQ-018 Reset asserted mid-MOVE or mid-LOST aborts immediately; the first cycle after release behaves as IDLE.

REQ-019 Reset does not depend on clock or tick.

Verification
REQ-020 Reset release with bar_x=320, bar_y=464 -> x=320, y=452, lives=3, estado=0, hit=0, lost=0.

REQ-021 IDLE, bar_x=200 -> x=200 next cycle; start=0 for one cycle -> estado=1; first tick -> x=204, y=448.

REQ-022 Launch at bar_x=576 -> after 15 ticks x=636 and dx left; tick 16 -> x=632; after 112 ticks from launch y=4 and dy down.

REQ-023 Descending ball with y=448, x=bar_x-10, bar_y=464, one tick -> y=452, dy up, dx left, hit pulses exactly one cycle.

REQ-024 Bar moved clear, ball descends to y+4 >= 476 -> lost pulse, lives 3->2, estado=2; after 60 ticks estado=0 and x tracks bar_x.

REQ-025 Third miss -> lives=0, estado=3, start=0 ignored; reset==0 mid-flight from any state -> REQ-017 values immediately, with no clock edge required.
